mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Arbitrates the shared word-wide data memory (memory_block) between requester A (instruction fetch, word read-only) and requester B (data load/store, word or byte).
- Owns all memory control signals and always issues word-aligned word accesses to the memory.
- Byte loads are extracted locally; byte stores are done as a read-modify-write (RMW) sequence.
- Sits between the CPU fetch/load-store units and memory_block.

Parameters:
- ADDR_W, 9, byte address width; word index = addr[ADDR_W-1:2].
- DATA_W, 32, data width; fixed at 32 because byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  A request; held high until a_done.
- a_addr  in  ADDR_W  A byte address; bits [1:0] ignored.
- a_done  out  1  one-cycle pulse; a_rdata valid this cycle.
- a_rdata  out  DATA_W  A read word.
- b_req  in  1  B request; held high until b_done.
- b_we  in  1  1 = store, 0 = load.
- b_byte  in  1  1 = byte access, 0 = word access.
- b_addr  in  ADDR_W  B byte address.
- b_wdata  in  DATA_W  store data; byte stores use [7:0].
- b_done  out  1  one-cycle completion pulse.
- b_rdata  out  DATA_W  load data; byte loads are zero-extended.
- mem_addr  out  ADDR_W  to memory; always {index, 2'b00}.
- mem_wdata  out  DATA_W  to memory.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory; write commits on the clk edge closing a cycle where this is high.
- mem_byte  out  1  to memory; tied 0.
- mem_rdata  in  DATA_W  from memory; combinational, valid in the cycle mem_read is high.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; last_gnt = B, so A wins the first tie.
  - All outputs are 0, including mem_write, which drops immediately.
  - An in-flight operation is aborted. No RMW write half is issued after reset. No done pulse is produced.
- Outputs are registered from state and the latched request fields.
- FSM states: IDLE, RD, WR, RESP.
- IDLE arbitration:
  - Exactly one of a_req/b_req high: that requester is granted.
  - Both high: grant the requester that is not last_gnt (round-robin), then update last_gnt.
  - On grant, latch addr, we, byte and wdata. A is always treated as a word read.
- IDLE to next state:
  - Word store: go to WR.
  - Any other access: go to RD.
- RD (mem_read=1): capture mem_rdata into data_q at the end of the cycle.
  - Byte store: go to WR with mem_wdata = merge(data_q, wdata[7:0], off).
  - Load or fetch: go to RESP.
- WR (mem_write=1, mem_read=0): go to RESP.
  - Word store: mem_wdata = latched wdata.
- RESP: pulse done for the granted requester and drive rdata, then go to IDLE.
  - Word load: rdata = data_q.
  - Byte load: rdata = {24'b0, lane(off)}, where off 00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24].
  - Stores: rdata = 0.
  - Non-granted done and rdata stay 0.
- Latency, with request accepted at edge k:
  - Read or word store: done in cycle k+2.
  - Byte store: done in cycle k+3.
  - Throughput: one access per 3–4 cycles.
- Boundary rules:
  - req deasserted mid-operation: the operation still completes and done still pulses.
  - req still high in the cycle after done: treated as a new request.
  - mem_read and mem_write are never high together.
  - Word accesses with addr[1:0]≠0 are silently aligned down. No error is raised.
  - Address 9'h1FF is valid; index 127 has no wrap concerns.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, RD, WR, RESP);
  - grant ID constants GNT_A/GNT_B;
  - byte-offset constants.
- Sub-module byte_lane_unit (combinational):
  - extract(word, off) → zero-extended byte;
  - merge(word, byte, off) → word.
- byte_lane_unit is shared by the RESP and WR paths.

Test Plan:
- Preload index 0 = 32'hDDCCBBAA. A fetch at addr 0 → a_done at k+2 with a_rdata=32'hDDCCBBAA. mem_read high exactly in cycle k+1.
- B byte load at addr 9'h002 → b_rdata=32'h000000CC. B word load at addr 9'h001 → 32'hDDCCBBAA (aligned down).
- B byte store of 8'h55 at addr 9'h001 over 32'hDDCCBBAA:
  - mem_read in k+1;
  - mem_write in k+2 with mem_wdata=32'hDDCC55AA;
  - b_done in k+3;
  - a subsequent read returns 32'hDDCC55AA.
- a_req and b_req both held high continuously: grants alternate A,B,A,B starting with A. Each done pulses exactly once per grant.
- B word store 32'hFFFFFFFF at addr 9'h01E → mem_write in k+1 only, mem_addr=9'h01C, b_done in k+2.
- Assert rst_n=0 during RD of a byte store:
  - mem_write is never asserted and no done pulses;
  - memory word is unchanged;
  - after release, A wins the first tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant and byte-offset definitions for the memory arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;
   localparam logic [1:0] OFF_B0 = 2'd0;
   localparam logic [1:0] OFF_B1 = 2'd1;
   localparam logic [1:0] OFF_B2 = 2'd2;
   localparam logic [1:0] OFF_B3 = 2'd3;
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: extracts one byte lane of a word and merges a byte into a word
module byte_lane_unit
   import mem_arb_pkg::*;
(
   input  logic [31:0] word,
   input  logic [7:0]  data,
   input  logic [1:0]  off,
   output logic [31:0] ext,
   output logic [31:0] merged
);
   // zero-extended lane select and single-lane replacement
   always_comb begin
      ext = {24'b0, off == OFF_B3 ? word[31:24] : off == OFF_B2 ? word[23:16] :
                    off == OFF_B1 ? word[15:8] : word[7:0]};
      merged = {off == OFF_B3 ? data : word[31:24], off == OFF_B2 ? data : word[23:16],
                off == OFF_B1 ? data : word[15:8], off == OFF_B0 ? data : word[7:0]};
   end
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sharing of one word memory between fetch (A) and load/store (B)
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_done,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic              b_byte,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_byte,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t state;
   logic last_gnt, gnt_q, we_q, byte_q, gnt;
   logic [1:0] off_q;
   logic [7:0] wbyte_q;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] lane_ext, lane_merged;

   assign mem_byte = 1'b0;
   // A wins when B is not asking or when B was served last
   assign gnt = (a_req && (!b_req || last_gnt == GNT_B)) ? GNT_A : GNT_B;
   assign sel_addr = gnt == GNT_A ? a_addr : b_addr;

   byte_lane_unit u_lane (
      .word   (mem_rdata),
      .data   (wbyte_q),
      .off    (off_q),
      .ext    (lane_ext),
      .merged (lane_merged)
   );

   // access sequencer; every output is registered alongside the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_gnt  <= GNT_B;
         gnt_q     <= GNT_A;
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         off_q     <= 2'd0;
         wbyte_q   <= 8'd0;
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         a_done    <= 1'b0;
         b_done    <= 1'b0;
         a_rdata   <= '0;
         b_rdata   <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: if (a_req || b_req) begin
               gnt_q     <= gnt;
               last_gnt  <= gnt;
               we_q      <= gnt == GNT_B && b_we;
               byte_q    <= gnt == GNT_B && b_byte;
               off_q     <= sel_addr[1:0];
               wbyte_q   <= b_wdata[7:0];
               mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
               mem_wdata <= b_wdata;
               if (gnt == GNT_B && b_we && !b_byte) begin
                  state     <= WR;
                  mem_write <= 1'b1;
               end else begin
                  state    <= RD;
                  mem_read <= 1'b1;
               end
            end
            RD: if (we_q) begin
               state     <= WR;
               mem_write <= 1'b1;
               mem_wdata <= lane_merged;
            end else begin
               state   <= RESP;
               a_done  <= gnt_q == GNT_A;
               b_done  <= gnt_q == GNT_B;
               a_rdata <= gnt_q == GNT_A ? mem_rdata : '0;
               b_rdata <= gnt_q == GNT_B ? (byte_q ? lane_ext : mem_rdata) : '0;
            end
            WR: begin
               state  <= RESP;
               a_done <= gnt_q == GNT_A;
               b_done <= gnt_q == GNT_B;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed and randomized checks of the memory arbiter against a transaction model
module tb_mem_access_arbiter;
   logic clk = 1'b0, rst_n = 1'b0;
   logic a_req = 1'b0, b_req = 1'b0, b_we = 1'b0, b_byte = 1'b0;
   logic [8:0] a_addr = '0, b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic a_done, b_done, mem_read, mem_write, mem_byte;
   logic [31:0] a_rdata, b_rdata, mem_wdata, mem_rdata;
   logic [8:0] mem_addr;
   logic [31:0] mem [128];
   logic [31:0] ref_mem [128];
   logic pre_we = 1'b0;
   logic [6:0] pre_idx = '0;
   logic [31:0] pre_val = '0;
   int checks = 0, errors = 0;
   logic rr_last_a;

   always #5 clk = ~clk;

   mem_access_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_addr(a_addr), .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_byte(b_byte), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_done(b_done), .b_rdata(b_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte(mem_byte), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[8:2]];
   always @(posedge clk)
      if (pre_we) mem[pre_idx] <= pre_val;
      else if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;

   task automatic preload_all();
      @(negedge clk);
      pre_we = 1'b1;
      for (int i = 0; i < 128; i++) begin
         pre_idx = 7'(i);
         pre_val = $urandom;
         ref_mem[i] = pre_val;
         @(negedge clk);
      end
      pre_we = 1'b0;
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 7'(idx); pre_val = val; ref_mem[idx] = val;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // transaction-level model of one B access: returns expected rdata, updates ref_mem
   task automatic model_b(input logic we, input logic byt, input logic [8:0] addr,
                          input logic [31:0] wd, output logic [31:0] exp);
      int idx, sh;
      idx = int'(addr) / 4;
      sh = 8 * (int'(addr) % 4);
      exp = 0;
      if (!we) exp = byt ? (ref_mem[idx] >> sh) & 32'hFF : ref_mem[idx];
      else if (byt) ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      else ref_mem[idx] = wd;
   endtask

   task automatic run_a(input logic [8:0] addr, output logic [31:0] rd, output int done_c,
                        output logic [7:0] rmask, output logic [7:0] wmask);
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = addr;
      rd = '0; done_c = 0; rmask = '0; wmask = '0;
      for (int c = 1; c <= 7 && done_c == 0; c++) begin
         @(posedge clk); #1;
         if (mem_read) rmask[c] = 1'b1;
         if (mem_write) wmask[c] = 1'b1;
         if (a_done) begin done_c = c; rd = a_rdata; end
      end
      a_req = 1'b0;
   endtask

   task automatic run_b(input logic we, input logic byt, input logic [8:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int done_c, output logic [7:0] rmask,
                        output logic [7:0] wmask, output logic [31:0] wr_data, output logic [8:0] wr_addr,
                        output logic a_seen);
      @(posedge clk); #1;
      b_req = 1'b1; b_we = we; b_byte = byt; b_addr = addr; b_wdata = wd;
      rd = '0; done_c = 0; rmask = '0; wmask = '0; wr_data = '0; wr_addr = '0; a_seen = 1'b0;
      for (int c = 1; c <= 7 && done_c == 0; c++) begin
         @(posedge clk); #1;
         if (mem_read) rmask[c] = 1'b1;
         if (mem_write) begin wmask[c] = 1'b1; wr_data = mem_wdata; wr_addr = mem_addr; end
         if (a_done) a_seen = 1'b1;
         if (b_done) begin done_c = c; rd = b_rdata; end
      end
      b_req = 1'b0;
   endtask

   task automatic test_reset();
      preload_all();
      checks++;
      if ({a_done, b_done, mem_read, mem_write, mem_byte} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b exp 00000", {a_done, b_done, mem_read, mem_write, mem_byte});
      end
      checks++;
      if ({a_rdata, b_rdata, mem_wdata, mem_addr} !== '0) begin
         errors++; $display("FAIL reset_data got %h exp 0", {a_rdata, b_rdata, mem_wdata, mem_addr});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      logic [31:0] rd; int dc; logic [7:0] rm, wm;
      preload(0, 32'hDDCCBBAA);
      run_a(9'h000, rd, dc, rm, wm);
      checks++;
      if (rd !== 32'hDDCCBBAA) begin errors++; $display("FAIL fetch_data got %h exp ddccbbaa", rd); end
      checks++;
      if (dc !== 2) begin errors++; $display("FAIL fetch_latency got %0d exp 2", dc); end
      checks++;
      if (rm !== 8'b0000_0010 || wm !== 8'b0) begin
         errors++; $display("FAIL fetch_strobes got rd=%b wr=%b exp rd=00000010 wr=00000000", rm, wm);
      end
   endtask

   task automatic test_byte_load();
      logic [31:0] rd, wd; int dc; logic [7:0] rm, wm; logic [8:0] wa; logic as;
      run_b(1'b0, 1'b1, 9'h002, 32'h0, rd, dc, rm, wm, wd, wa, as);
      checks++;
      if (rd !== 32'h000000CC || dc !== 2) begin
         errors++; $display("FAIL byte_load got %h@%0d exp 000000cc@2", rd, dc);
      end
      run_b(1'b0, 1'b0, 9'h001, 32'h0, rd, dc, rm, wm, wd, wa, as);
      checks++;
      if (rd !== 32'hDDCCBBAA || dc !== 2) begin
         errors++; $display("FAIL word_load_align got %h@%0d exp ddccbbaa@2", rd, dc);
      end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd, wd; int dc; logic [7:0] rm, wm; logic [8:0] wa; logic as;
      run_b(1'b1, 1'b1, 9'h001, {$urandom_range(0, 32'hFFFFFF), 8'h55}, rd, dc, rm, wm, wd, wa, as);
      ref_mem[0] = 32'hDDCC55AA;
      checks++;
      if (rm !== 8'b0000_0010 || wm !== 8'b0000_0100) begin
         errors++; $display("FAIL bstore_strobes got rd=%b wr=%b exp rd=00000010 wr=00000100", rm, wm);
      end
      checks++;
      if (wd !== 32'hDDCC55AA || wa !== 9'h000) begin
         errors++; $display("FAIL bstore_wdata got %h@%h exp ddcc55aa@000", wd, wa);
      end
      checks++;
      if (dc !== 3 || rd !== 32'h0 || as !== 1'b0) begin
         errors++; $display("FAIL bstore_done got lat=%0d rd=%h a=%b exp lat=3 rd=0 a=0", dc, rd, as);
      end
      run_a(9'h000, rd, dc, rm, wm);
      checks++;
      if (rd !== 32'hDDCC55AA) begin errors++; $display("FAIL bstore_readback got %h exp ddcc55aa", rd); end
   endtask

   task automatic test_word_store();
      logic [31:0] rd, wd; int dc; logic [7:0] rm, wm; logic [8:0] wa; logic as;
      run_b(1'b1, 1'b0, 9'h01E, 32'hFFFFFFFF, rd, dc, rm, wm, wd, wa, as);
      ref_mem[7] = 32'hFFFFFFFF;
      checks++;
      if (rm !== 8'b0 || wm !== 8'b0000_0010 || wa !== 9'h01C) begin
         errors++; $display("FAIL wstore_strobes got rd=%b wr=%b addr=%h exp rd=0 wr=00000010 addr=01c", rm, wm, wa);
      end
      checks++;
      if (dc !== 2 || mem[7] !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL wstore_commit got lat=%0d mem=%h exp lat=2 mem=ffffffff", dc, mem[7]);
      end
   endtask

   task automatic test_top_address();
      logic [31:0] rd, wd; int dc; logic [7:0] rm, wm; logic [8:0] wa; logic as;
      preload(127, 32'h9A785634);
      run_b(1'b0, 1'b1, 9'h1FF, 32'h0, rd, dc, rm, wm, wd, wa, as);
      checks++;
      if (rd !== 32'h0000009A) begin errors++; $display("FAIL top_byte got %h exp 0000009a", rd); end
      run_a(9'h1FF, rd, dc, rm, wm);
      checks++;
      if (rd !== 32'h9A785634) begin errors++; $display("FAIL top_fetch got %h exp 9a785634", rd); end
   endtask

   task automatic test_reset_mid();
      logic bad; int first;
      preload(1, 32'h11223344);
      @(posedge clk); #1;
      b_req = 1'b1; b_we = 1'b1; b_byte = 1'b1; b_addr = 9'h005; b_wdata = 32'hEE;
      @(posedge clk); #1;
      checks++;
      if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_in_rd got %b exp 1", mem_read); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_done, b_done, mem_read, mem_write, a_rdata, b_rdata, mem_addr, mem_wdata} !== '0) begin
         errors++; $display("FAIL rmid_clear got %b%b%b%b exp 0000", a_done, b_done, mem_read, mem_write);
      end
      b_req = 1'b0;
      bad = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (mem_write || a_done || b_done) bad = 1'b1; end
      @(negedge clk) rst_n = 1'b1;
      repeat (4) begin @(posedge clk); #1; if (mem_write || a_done || b_done) bad = 1'b1; end
      checks++;
      if (bad !== 1'b0) begin errors++; $display("FAIL rmid_quiet got activity exp none"); end
      checks++;
      if (mem[1] !== 32'h11223344) begin errors++; $display("FAIL rmid_mem got %h exp 11223344", mem[1]); end
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 9'h004; b_req = 1'b1; b_we = 1'b0; b_byte = 1'b0; b_addr = 9'h008;
      first = 0;
      for (int c = 0; c < 12 && (a_req || b_req); c++) begin
         @(posedge clk); #1;
         if (a_done) begin if (first == 0) first = 1; a_req = 1'b0; end
         if (b_done) begin if (first == 0) first = 2; b_req = 1'b0; end
      end
      a_req = 1'b0; b_req = 1'b0;
      checks++;
      if (first !== 1) begin errors++; $display("FAIL rmid_tie got %0d exp 1", first); end
   endtask

   task automatic test_round_robin();
      int seq[$]; int at[$]; logic both; logic [31:0] ea, eb;
      ea = ref_mem[4];
      eb = (ref_mem[6] >> 24) & 32'hFF;
      both = 1'b0;
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 9'h010; b_req = 1'b1; b_we = 1'b0; b_byte = 1'b1; b_addr = 9'h01B;
      for (int c = 1; c <= 23; c++) begin
         @(posedge clk); #1;
         if (a_done && b_done) both = 1'b1;
         if (a_done) begin
            seq.push_back(1); at.push_back(c);
            checks++;
            if (a_rdata !== ea) begin errors++; $display("FAIL rr_a_data got %h exp %h", a_rdata, ea); end
         end
         if (b_done) begin
            seq.push_back(2); at.push_back(c);
            checks++;
            if (b_rdata !== eb) begin errors++; $display("FAIL rr_b_data got %h exp %h", b_rdata, eb); end
         end
         if (c == 19) begin a_req = 1'b0; b_req = 1'b0; end
      end
      checks++;
      if (seq.size() != 7 || both) begin
         errors++; $display("FAIL rr_count got %0d both=%b exp 7 both=0", seq.size(), both);
      end
      foreach (seq[i]) begin
         checks++;
         if (seq[i] != (i % 2 == 0 ? 1 : 2) || at[i] != 2 + 3 * i) begin
            errors++; $display("FAIL rr_order[%0d] got %0d@%0d exp %0d@%0d", i, seq[i], at[i], i % 2 == 0 ? 1 : 2, 2 + 3 * i);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, ea, eb, wdv; int dc, first, bad_words; logic [7:0] rm, wm; logic [8:0] wa, aa, ba;
      logic as, we, byt, coll, a_win;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      rr_last_a = 1'b0;
      for (int it = 0; it < 60; it++) begin
         int mode;
         mode = $urandom_range(0, 2);
         aa = {($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(8, 15)), 2'($urandom)};
         ba = {($urandom_range(0, 3) == 0) ? 7'd127 : 7'($urandom_range(8, 15)), 2'($urandom)};
         we = 1'($urandom); byt = 1'($urandom); wdv = $urandom;
         if (mode == 0) begin
            ea = ref_mem[aa[8:2]];
            run_a(aa, rd, dc, rm, wm);
            rr_last_a = 1'b1;
            checks++;
            if (rd !== ea || dc !== 2 || wm !== 8'b0) begin
               errors++; $display("FAIL rnd_a[%0d] got %h@%0d exp %h@2", it, rd, dc, ea);
            end
         end else if (mode == 1) begin
            model_b(we, byt, ba, wdv, eb);
            run_b(we, byt, ba, wdv, rd, dc, rm, wm, wd, wa, as);
            rr_last_a = 1'b0;
            checks++;
            if (rd !== eb || dc !== ((we && byt) ? 3 : 2) || (rm & wm) !== 8'b0) begin
               errors++; $display("FAIL rnd_b[%0d] got %h@%0d exp %h@%0d", it, rd, dc, eb, (we && byt) ? 3 : 2);
            end
         end else begin
            a_win = !rr_last_a;
            if (a_win) begin ea = ref_mem[aa[8:2]]; model_b(we, byt, ba, wdv, eb); end
            else begin model_b(we, byt, ba, wdv, eb); ea = ref_mem[aa[8:2]]; end
            rr_last_a = !a_win;
            @(posedge clk); #1;
            a_req = 1'b1; a_addr = aa; b_req = 1'b1; b_we = we; b_byte = byt; b_addr = ba; b_wdata = wdv;
            first = 0; coll = 1'b0;
            for (int c = 0; c < 14 && (a_req || b_req); c++) begin
               @(posedge clk); #1;
               if ((a_done && b_done) || (mem_read && mem_write) || mem_byte) coll = 1'b1;
               if (a_done) begin
                  if (first == 0) first = 1;
                  a_req = 1'b0;
                  checks++;
                  if (a_rdata !== ea) begin errors++; $display("FAIL rnd_dual_a[%0d] got %h exp %h", it, a_rdata, ea); end
               end
               if (b_done) begin
                  if (first == 0) first = 2;
                  b_req = 1'b0;
                  checks++;
                  if (b_rdata !== eb) begin errors++; $display("FAIL rnd_dual_b[%0d] got %h exp %h", it, b_rdata, eb); end
               end
            end
            checks++;
            if (first != (a_win ? 1 : 2) || coll || a_req || b_req) begin
               errors++; $display("FAIL rnd_dual_order[%0d] got first=%0d coll=%b pend=%b%b exp first=%0d", it, first, coll, a_req, b_req, a_win ? 1 : 2);
            end
            a_req = 1'b0; b_req = 1'b0;
         end
      end
      bad_words = 0;
      for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad_words++;
      checks++;
      if (bad_words != 0) begin errors++; $display("FAIL rnd_memory got %0d differing words exp 0", bad_words); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_byte_load();
      test_byte_store();
      test_word_store();
      test_top_address();
      test_reset_mid();
      test_round_robin();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
